// File: rtl/tarsier_pkg.sv
// Shared luma-pyramid types and constants: pixel/coordinate types, the
// 3x3 binomial kernel taps and its rounding constants.
package tarsier_pkg;

    localparam int LUMA_BITS       = 8;
    localparam int COORD_BITS      = 16;
    localparam int MAX_INPUT_WIDTH = 640;
    localparam int LB_ADDR_BITS    = $clog2(MAX_INPUT_WIDTH);
    localparam int SUM_BITS        = LUMA_BITS + 4;

    typedef logic [LUMA_BITS-1:0]           luma_t;
    typedef logic [COORD_BITS-1:0]          coord_t;
    typedef logic [SUM_BITS-1:0]            sum_t;
    typedef logic [2:0][2:0][LUMA_BITS-1:0] window_t;

    // Separable kernel [1 2 1]^T * [1 2 1]; taps sum to 16.
    localparam int   KERNEL_TAP [3] = '{1, 2, 1};
    localparam sum_t ROUND_CONST    = sum_t'(8);
    localparam int   ROUND_SHIFT    = 4;

    function automatic sum_t kernel_sum(input window_t win);
        sum_t acc;
        acc = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                acc = acc + sum_t'(win[r][c]) * sum_t'(KERNEL_TAP[r] * KERNEL_TAP[c]);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/line_buffer_dp.sv
// Simple dual-port line RAM with synchronous read; a read and write to the
// same address in one cycle returns the old contents.
module line_buffer_dp
    import tarsier_pkg::*;
#(
    parameter int DEPTH     = MAX_INPUT_WIDTH,
    parameter int WIDTH     = LUMA_BITS,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
        if (rd_en) rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/gaussian_blur_3x3.sv
// Streaming 3x3 binomial blur with two line buffers and a 2-cycle pipeline.
// Optional GAUSS_BLUR_BYPASS_EN adds r_bypass, passing the raw window centre.
module gaussian_blur_3x3
    import tarsier_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [COORD_BITS-1:0] r_width,
`ifdef GAUSS_BLUR_BYPASS_EN
    input  logic                  r_bypass,
`endif
    input  logic [LUMA_BITS-1:0]  in_pixel,
    input  logic                  in_valid,
    input  logic [COORD_BITS-1:0] in_x,
    input  logic [COORD_BITS-1:0] in_y,
    output logic [LUMA_BITS-1:0]  out_pixel,
    output logic                  out_valid,
    output logic [COORD_BITS-1:0] out_x,
    output logic [COORD_BITS-1:0] out_y
);

    logic                    accept;
    logic [LB_ADDR_BITS-1:0] lb_addr;
    luma_t                   lb0_rd, lb1_rd;

    logic [1:0] col_run_d, col_run_q;
    logic [1:0] rows_done_d, rows_done_q;
    logic       seen_x0_d, seen_x0_q;
    coord_t     last_x_d, last_x_q;

    logic                    s0_valid_d, s0_valid_q;
    logic                    s0_emit_d, s0_emit_q;
    logic                    s0_fwd_d, s0_fwd_q;
    logic [LB_ADDR_BITS-1:0] s0_addr_d, s0_addr_q;
    luma_t                   s0_pixel_d, s0_pixel_q;
    coord_t                  s0_ox_d, s0_ox_q, s0_oy_d, s0_oy_q;
    luma_t                   lb1_hold_d, lb1_hold_q;

    window_t win_d, win_q;
    logic    s1_emit_d, s1_emit_q;
    coord_t  s1_ox_d, s1_ox_q, s1_oy_d, s1_oy_q;

    sum_t   sum;
    luma_t  filtered, result;
    logic   out_valid_d, out_valid_q;
    luma_t  out_pixel_d, out_pixel_q;
    coord_t out_x_d, out_x_q, out_y_d, out_y_q;

    assign accept  = in_valid && (in_x < r_width) && !reset;
    assign lb_addr = in_x[LB_ADDR_BITS-1:0];

    // lb0 is read and rewritten on the accept edge; lb1 takes lb0's old
    // value one edge later, once that read data exists.
    line_buffer_dp u_lb0 (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (lb_addr),
        .wr_data (in_pixel),
        .rd_en   (accept),
        .rd_addr (lb_addr),
        .rd_data (lb0_rd)
    );

    line_buffer_dp u_lb1 (
        .clk     (clk),
        .wr_en   (s0_valid_q),
        .wr_addr (s0_addr_q),
        .wr_data (lb0_rd),
        .rd_en   (accept),
        .rd_addr (lb_addr),
        .rd_data (lb1_rd)
    );

    always_comb begin
        col_run_d   = col_run_q;
        rows_done_d = rows_done_q;
        seen_x0_d   = seen_x0_q;
        last_x_d    = last_x_q;
        if (accept) begin
            if (in_x == '0)
                col_run_d = 2'd1;
            else if (in_x == last_x_q + coord_t'(1))
                col_run_d = (col_run_q == 2'd3) ? 2'd3 : col_run_q + 2'd1;
            else
                col_run_d = 2'd1;
            last_x_d = in_x;
            if (in_x == '0) seen_x0_d = 1'b1;
            // Only rows whose start was seen since reset count as complete.
            if ((in_x == r_width - coord_t'(1)) && seen_x0_q && (rows_done_q != 2'd2))
                rows_done_d = rows_done_q + 2'd1;
        end

        s0_valid_d = accept;
        s0_emit_d  = accept && (col_run_d == 2'd3) && (rows_done_q == 2'd2);
        // Back-to-back hit on one address: lb1 write is still in flight.
        s0_fwd_d   = accept && s0_valid_q && (s0_addr_q == lb_addr);
        s0_addr_d  = accept ? lb_addr : s0_addr_q;
        s0_pixel_d = accept ? in_pixel : s0_pixel_q;
        s0_ox_d    = accept ? in_x - coord_t'(2) : s0_ox_q;
        s0_oy_d    = accept ? in_y - coord_t'(2) : s0_oy_q;
        lb1_hold_d = s0_valid_q ? lb0_rd : lb1_hold_q;

        win_d     = win_q;
        s1_emit_d = s0_emit_q;
        s1_ox_d   = s1_ox_q;
        s1_oy_d   = s1_oy_q;
        if (s0_valid_q) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = s0_fwd_q ? lb1_hold_q : lb1_rd;
            win_d[1][2] = lb0_rd;
            win_d[2][2] = s0_pixel_q;
            s1_ox_d     = s0_ox_q;
            s1_oy_d     = s0_oy_q;
        end

        sum      = kernel_sum(win_q);
        filtered = luma_t'((sum + ROUND_CONST) >> ROUND_SHIFT);
`ifdef GAUSS_BLUR_BYPASS_EN
        result   = r_bypass ? win_q[1][1] : filtered;
`else
        result   = filtered;
`endif
        out_valid_d = s1_emit_q;
        out_pixel_d = s1_emit_q ? result  : out_pixel_q;
        out_x_d     = s1_emit_q ? s1_ox_q : out_x_q;
        out_y_d     = s1_emit_q ? s1_oy_q : out_y_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_run_q   <= '0;
            rows_done_q <= '0;
            seen_x0_q   <= 1'b0;
            last_x_q    <= '0;
            s0_valid_q  <= 1'b0;
            s0_emit_q   <= 1'b0;
            s0_fwd_q    <= 1'b0;
            s1_emit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
        end else begin
            col_run_q   <= col_run_d;
            rows_done_q <= rows_done_d;
            seen_x0_q   <= seen_x0_d;
            last_x_q    <= last_x_d;
            s0_valid_q  <= s0_valid_d;
            s0_emit_q   <= s0_emit_d;
            s0_fwd_q    <= s0_fwd_d;
            s1_emit_q   <= s1_emit_d;
            out_valid_q <= out_valid_d;
            out_pixel_q <= out_pixel_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
        end
    end

    always_ff @(posedge clk) begin
        s0_addr_q  <= s0_addr_d;
        s0_pixel_q <= s0_pixel_d;
        s0_ox_q    <= s0_ox_d;
        s0_oy_q    <= s0_oy_d;
        lb1_hold_q <= lb1_hold_d;
        win_q      <= win_d;
        s1_ox_q    <= s1_ox_d;
        s1_oy_q    <= s1_oy_d;
    end

    assign out_valid = out_valid_q;
    assign out_pixel = out_pixel_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;

endmodule

// File: tb/tb_gaussian_blur_3x3.sv
// Scoreboard bench for gaussian_blur_3x3: a line-buffer/window reference model
// predicts each output (value, coordinates, cycle); a monitor pops and compares.
`timescale 1ns/1ps
module tb_gaussian_blur_3x3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] r_width = 16'd6;
    logic [7:0]  in_pixel = '0;
    logic        in_valid = 1'b0;
    logic [15:0] in_x = '0, in_y = '0;
    logic [7:0]  out_pixel;
    logic        out_valid;
    logic [15:0] out_x, out_y;
`ifdef GAUSS_BLUR_BYPASS_EN
    logic        r_bypass = 1'b0;
`endif

    gaussian_blur_3x3 dut (
        .clk       (clk),
        .reset     (reset),
        .r_width   (r_width),
`ifdef GAUSS_BLUR_BYPASS_EN
        .r_bypass  (r_bypass),
`endif
        .in_pixel  (in_pixel),
        .in_valid  (in_valid),
        .in_x      (in_x),
        .in_y      (in_y),
        .out_pixel (out_pixel),
        .out_valid (out_valid),
        .out_x     (out_x),
        .out_y     (out_y)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int pix; int x; int y; int cyc; } exp_t;
    exp_t sb [$];

    int checks = 0, errors = 0;
    int n_out_test = 0, m_pushed_test = 0;
    int first_x = -1, first_y = -1;
    int obs [16][16];
    int ramp_ref [16][16];
    int img [16][16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: line buffers, window columns and counters as plain arrays.
    int m_lb0 [640], m_lb1 [640];
    int m_win [3][3];
    int m_cr = 0, m_rows = 0, m_last = 0, m_w = 6;
    bit m_seen0 = 0, m_bypass = 0;
    int kw [3] = '{1, 2, 1};

    task automatic m_reset(input int edge_n);
        m_cr = 0; m_rows = 0; m_seen0 = 0;
        while (sb.size() > 0 && sb[$].cyc >= edge_n) void'(sb.pop_back());
    endtask

    task automatic m_step(input int x, input int y, input int pix, input int edge_n);
        int top, mid, sum;
        bit emit;
        exp_t e;
        if (x >= m_w) return;
        top = m_lb1[x]; mid = m_lb0[x];
        m_lb1[x] = mid; m_lb0[x] = pix;
        for (int r = 0; r < 3; r++) begin
            m_win[r][0] = m_win[r][1];
            m_win[r][1] = m_win[r][2];
        end
        m_win[0][2] = top; m_win[1][2] = mid; m_win[2][2] = pix;
        if (x == 0) m_cr = 1;
        else if (x == m_last + 1) m_cr = (m_cr < 3) ? m_cr + 1 : 3;
        else m_cr = 1;
        m_last = x;
        emit = (m_cr >= 3) && (m_rows == 2);
        if (x == 0) m_seen0 = 1;
        if (x == m_w - 1 && m_seen0 && m_rows < 2) m_rows++;
        if (emit) begin
            sum = 0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    sum += m_win[r][c] * kw[r] * kw[c];
            e.pix = m_bypass ? m_win[1][1] : (sum + 8) / 16;
            e.x = x - 2; e.y = y - 2; e.cyc = edge_n + 2;
            sb.push_back(e);
            m_pushed_test++;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            if (n_out_test == 0) begin first_x = out_x; first_y = out_y; end
            n_out_test++;
            if (out_x < 16 && out_y < 16) obs[out_y][out_x] = out_pixel;
            if (sb.size() == 0) begin
                chk("spurious_out_valid", int'(out_valid), 0);
            end else begin
                e = sb.pop_front();
                chk("out_pixel", int'(out_pixel), e.pix);
                chk("out_x", int'(out_x), e.x);
                chk("out_y", int'(out_y), e.y);
                chk("out_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic send(input bit vld, input int x, input int y, input int pix);
        in_valid = vld; in_x = 16'(x); in_y = 16'(y); in_pixel = 8'(pix);
        if (vld) m_step(x, y, pix, cyc + 1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) send(0, 0, 0, 0);
    endtask

    task automatic do_reset(input bit with_sample, input int x, input int y, input int pix);
        reset = 1'b1; in_valid = with_sample;
        in_x = 16'(x); in_y = 16'(y); in_pixel = 8'(pix);
        m_reset(cyc + 1);
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
    endtask

    task automatic begin_test(input int w);
        n_out_test = 0; m_pushed_test = 0; first_x = -1; first_y = -1;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) obs[y][x] = -1;
        r_width = 16'(w); m_w = w;
        do_reset(0, 0, 0, 0);
    endtask

    task automatic end_test(input string name, input int exp_count);
        idle(6);
        chk({name, "_count"}, n_out_test, exp_count);
        chk({name, "_pending"}, sb.size(), 0);
        sb.delete();
    endtask

    task automatic stream(input int w, input int h, input int gap_pct, input bit oor,
                          input int skip_y, input int skip_x, input int dup_y, input int dup_x,
                          input int rst_y, input int rst_x);
        int n;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (y == skip_y && x == skip_x) continue;
                n = ($urandom_range(99) < gap_pct) ? $urandom_range(1, 3) : 0;
                if (n > 0) idle(n);
                if (oor && $urandom_range(9) == 0) send(1, w + $urandom_range(0, 4), y, $urandom_range(255));
                if (y == rst_y && x == rst_x) begin
                    do_reset(1, x, y, img[y][x]);
                    continue;
                end
                send(1, x, y, img[y][x]);
                if (y == dup_y && x == dup_x) send(1, x, y, img[y][x] ^ 8'h5a);
            end
        end
    endtask

    task automatic fill(input int val);
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) img[y][x] = val;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, h;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_pixel", int'(out_pixel), 0);
        chk("rst_out_x", int'(out_x), 0);
        chk("rst_out_y", int'(out_y), 0);

        // Constant 6x4 image.
        begin_test(6);
        fill(8'h40);
        stream(6, 4, 0, 0, -1, -1, -1, -1, -1, -1);
        end_test("const", 8);
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++) chk("const_value", obs[y][x], 8'h40);
        chk("const_first_x", first_x, 0);
        chk("const_first_y", first_y, 0);

        // Impulse 5x5.
        begin_test(5);
        fill(0); img[2][2] = 8'hff;
        stream(5, 5, 0, 0, -1, -1, -1, -1, -1, -1);
        end_test("impulse", 9);
        chk("impulse_11", obs[1][1], 8'h40);
        chk("impulse_01", obs[1][0], 8'h20);
        chk("impulse_10", obs[0][1], 8'h20);
        chk("impulse_00", obs[0][0], 8'h10);
        chk("impulse_22", obs[2][2], 8'h10);

        // Saturation and rounding on 3x3 frames.
        begin_test(3);
        fill(8'hff);
        stream(3, 3, 0, 0, -1, -1, -1, -1, -1, -1);
        end_test("sat", 1);
        chk("sat_value", obs[0][0], 8'hff);
        begin_test(3);
        fill(8'h01);
        stream(3, 3, 0, 0, -1, -1, -1, -1, -1, -1);
        end_test("round", 1);
        chk("round_value", obs[0][0], 8'h01);

        // Ramp gap-free, then with gaps and out-of-range samples.
        begin_test(6);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 6; x++) img[y][x] = x * 16 + y * 32;
        stream(6, 4, 0, 0, -1, -1, -1, -1, -1, -1);
        end_test("ramp", 8);
        ramp_ref = obs;
        begin_test(6);
        stream(6, 4, 40, 1, -1, -1, -1, -1, -1, -1);
        end_test("ramp_gaps", 8);
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++) chk("ramp_gaps_value", obs[y][x], ramp_ref[y][x]);

        // Non-contiguous in_x restarts the column run.
        begin_test(8);
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 8; x++) img[y][x] = $urandom_range(255);
        stream(8, 5, 0, 0, 3, 4, -1, -1, -1, -1);
        end_test("skip", 15);

        // Reset mid-frame at (3,2) of 8x6.
        begin_test(8);
        for (int y = 0; y < 6; y++)
            for (int x = 0; x < 8; x++) img[y][x] = $urandom_range(255);
        stream(8, 6, 0, 0, -1, -1, -1, -1, 2, 3);
        end_test("midreset", 6);
        chk("midreset_first_x", first_x, 0);
        chk("midreset_first_y", first_y, 3);

        // Random frames with gaps, out-of-range samples and a repeated address.
        for (int t = 0; t < 4; t++) begin
            w = $urandom_range(3, 12);
            h = $urandom_range(3, 8);
            begin_test(w);
            for (int y = 0; y < h; y++)
                for (int x = 0; x < w; x++) img[y][x] = $urandom_range(255);
            stream(w, h, 20, 1, -1, -1, $urandom_range(2, h - 1), $urandom_range(0, w - 1), -1, -1);
            end_test("random", m_pushed_test);
        end

`ifdef GAUSS_BLUR_BYPASS_EN
        r_bypass = 1'b1; m_bypass = 1'b1;
        begin_test(5);
        fill(0); img[2][2] = 8'hff;
        stream(5, 5, 0, 0, -1, -1, -1, -1, -1, -1);
        end_test("bypass", 9);
        chk("bypass_11", obs[1][1], 8'hff);
        chk("bypass_00", obs[0][0], 0);
        chk("bypass_12", obs[1][2], 0);
        r_bypass = 1'b0; m_bypass = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gaussian_blur_3x3.md
# gaussian_blur_3x3

- Streaming 3×3 binomial (Gaussian) low-pass filter for the luma pyramid.
- Sits directly downstream of `Scale_1_2_Bilinear` and consumes its raster pixel stream (`pixel`, `valid`, `x`, `y`) unchanged, with no backpressure.
- Emits one smoothed pixel per fully populated window, using two internal line buffers, so the feature-detection stages see a denoised, border-cropped image.

## Interface
- `LUMA_BITS`, 8, pixel width.
- `MAX_INPUT_WIDTH`, 640, line-buffer depth (largest legal `r_width`).
- `COORD_BITS`, 16, width of coordinates and `r_width`.
- `clk`  in  1  single clock; everything is on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `r_width`  in  COORD_BITS  input row width, range 3..MAX_INPUT_WIDTH; static while streaming.
- `in_pixel`  in  LUMA_BITS  input luma.
- `in_valid`  in  1  qualifies `in_pixel`/`in_x`/`in_y`.
- `in_x`, `in_y`  in  COORD_BITS each  input pixel coordinates, raster order.
- `out_pixel`  out  LUMA_BITS  filtered luma.
- `out_valid`  out  1  qualifies all `out_*`.
- `out_x`, `out_y`  out  COORD_BITS each  cropped-frame coordinates of `out_pixel`.

## Operation
- **Accepted sample:** `in_valid` = 1 and `in_x` < `r_width`. Any other cycle is ignored and changes no state.
- **Line buffers:** `lb0` holds row y-1 and `lb1` holds row y-2. On each accepted sample at address `in_x`: `lb1[x]` ← `lb0[x]`, then `lb0[x]` ← `in_pixel` (read-before-write).
- **Window:** 3×3 register window shifts one column per accepted sample. The new column is {`lb1[x]`, `lb0[x]`, `in_pixel`}.
- **Column run `col_run`** (saturates at 3):
  - `in_x` == 0 → 1.
  - `in_x` == last accepted `in_x` + 1 → increment.
  - Otherwise → 1.
- **Row count `rows_done`** (saturates at 2): increments when a sample with `in_x` == `r_width`-1 is accepted.
- **Emit condition:** `col_run` reaches ≥3 on this sample and `rows_done` == 2. The window centre is then (`in_x`-1, `in_y`-1).
- **Arithmetic:**
  - Kernel is [1 2 1]ᵀ·[1 2 1].
  - Sum width is LUMA_BITS+4, unsigned.
  - `out_pixel` = (sum + 8) >> 4. This never exceeds 2^LUMA_BITS-1, so no clamp is needed.
- **Coordinates:** `out_x` = `in_x`-2, `out_y` = `in_y`-2. The output frame is (`r_width`-2) × (height-2). Border rows and columns are never emitted.
- **Reset:**
  - Clears `col_run`, `rows_done` and the pipeline valid bits.
  - Line-buffer RAM is not cleared; stale data is masked by `rows_done`.
  - Reset mid-frame: no output until two complete rows have been accepted after reset.

## Timing
- **Reset values:** `out_valid` = 0; `out_pixel`, `out_x`, `out_y` = 0.
- **Latency:** 2 cycles. A sample accepted at edge N that satisfies the emit condition drives `out_*` registered at edge N+2.
- **Stages:**
  - Stage 1 (edge N+1): line-buffer read, window shift, coordinate capture.
  - Stage 2 (edge N+2): weighted sum, rounding, output register.
- **Throughput:** one output per clock sustained.
- **Gaps:** `in_valid` gaps mid-row are legal. The pipeline holds no partial state and emits nothing for gap cycles.
- **Out-of-range `in_x`** (≥ `r_width`) with `in_valid` = 1: sample is dropped and `col_run` is unaffected.
- **`reset` and `in_valid` in the same cycle:** reset wins and the sample is discarded. `out_valid` is 0 on the following two edges.

## Configuration
- **`GAUSS_BLUR_BYPASS_EN`**
  - Defined: adds input port `r_bypass` (1 bit, static per frame). When `r_bypass` = 1, `out_pixel` is the raw window centre. Latency, coordinates, cropping and `out_valid` timing are identical to filtered mode.
  - Undefined: the port is absent and output is always filtered.

## Structure
- **Shared package `tarsier_pkg`:** `luma_t` typedef, `coord_t` typedef, kernel weight constants, rounding constant (8) and shift (4).
- **Sub-module `line_buffer_dp`:** one instance per line. Simple dual-port RAM, depth MAX_INPUT_WIDTH, width LUMA_BITS, synchronous read, read-before-write on same address. Must infer block RAM.
- **Top level:** window registers, run and row counters, adder tree, output pipeline.

## Test plan
- **Constant image:** 6×4 image of 0x40 → exactly 8 outputs, all 0x40, coordinates (0..3, 0..1) in raster order, each 2 cycles after the input at (x+2, y+2).
- **Impulse:** 5×5 zeros with 0xFF at (2,2) → out(1,1) = 0x40, out(0,1) = out(1,0) = 0x20, out(0,0) = 0x10, all others from the impulse accordingly.
- **Saturation and rounding:** 3×3 all 0xFF → single output 0xFF at (0,0). 3×3 all 0x01 → 0x01.
- **Gaps:** same 6×4 ramp with `in_valid` deasserted on random cycles → identical output values and coordinates as the gap-free run. Non-contiguous `in_x` restarts the run and suppresses the next two columns.
- **Reset mid-frame:** assert `reset` at (3,2) of an 8×6 frame → `out_valid` stays 0 until the sample at (2,5) is accepted; first output is (0,3).
- **Bypass** (`GAUSS_BLUR_BYPASS_EN` defined, `r_bypass` = 1): impulse image → out(1,1) = 0xFF and all other outputs 0x00, same timing as the impulse test.
